// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for an upstream Fibonacci LFSR stream.
// Seeds a local predictor from the stream, locks after a run of good predictions, then flags mismatches.
module lfsr_seq_checker #(
    parameter int unsigned     W         = 4,
    parameter logic [W-1:0]    TAPS      = W'(4'b1100),
    parameter int unsigned     LOCK_CNT  = 4,
    parameter int unsigned     ERR_LIMIT = 3
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic [W-1:0] In,
    input  logic         In_Valid,
    output logic         Locked,
    output logic         Err,
    output logic [15:0]  Err_Count
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ERR_W   = 16;
    localparam logic [CNT_W-1:0] LOCK_CNT_V  = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] ERR_LIMIT_V = CNT_W'(ERR_LIMIT);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       pred_q, pred_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]   err_run_q, err_run_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   match_inc;
    logic [CNT_W-1:0]   run_inc;

    // One LFSR step using the same polynomial as the upstream generator.
    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] cur);
        return {cur[W-2:0], ^(cur & TAPS)};
    endfunction

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= SEED;
            pred_q      <= '0;
            match_cnt_q <= '0;
            err_run_q   <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_cnt_q <= match_cnt_d;
            err_run_q   <= err_run_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        match_cnt_d = match_cnt_q;
        err_run_d   = err_run_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        match_inc   = match_cnt_q + CNT_W'(1);
        run_inc     = err_run_q + CNT_W'(1);

        if (In_Valid) begin
            case (state_q)
                SEED: begin
                    // All-zero is the LFSR lock-up value and cannot seed a predictor.
                    if (In != '0) begin
                        pred_d      = lfsr_next(In);
                        match_cnt_d = '0;
                        state_d     = HUNT;
                    end
                end
                HUNT: begin
                    if (In == pred_q) begin
                        pred_d      = lfsr_next(In);
                        match_cnt_d = match_inc;
                        if (match_inc == LOCK_CNT_V) begin
                            state_d   = LOCKED;
                            locked_d  = 1'b1;
                            err_run_d = '0;
                        end
                    end else if (In != '0) begin
                        pred_d      = lfsr_next(In);
                        match_cnt_d = '0;
                    end else begin
                        state_d = SEED;
                    end
                end
                LOCKED: begin
                    // Flywheel: predictor free-runs so isolated corruption does not desync it.
                    pred_d = lfsr_next(pred_q);
                    if (In == pred_q) begin
                        err_run_d = '0;
                    end else begin
                        err_d     = 1'b1;
                        err_run_d = run_inc;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        if (run_inc == ERR_LIMIT_V) begin
                            state_d   = SEED;
                            locked_d  = 1'b0;
                            err_run_d = '0;
                        end
                    end
                end
                default: begin
                    state_d  = SEED;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    assign Locked    = locked_q;
    assign Err       = err_q;
    assign Err_Count = err_count_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed vector table, hand-written corner sequences,
// randomized stream against a behavioural model, and counter saturation on a second instance.
module tb_lfsr_seq_checker;

    localparam int unsigned W    = 4;
    localparam int LCNT = 4;
    localparam int ELIM = 3;

    logic        Clk = 1'b0;
    logic        rst, valid;
    logic [3:0]  din;
    logic        locked, err;
    logic [15:0] err_count;

    logic        s_rst, s_valid;
    logic [3:0]  s_din;
    logic        s_locked, s_err;
    logic [15:0] s_count;

    int checks = 0;
    int fails  = 0;

    always #5 Clk = ~Clk;

    lfsr_seq_checker #(.W(4), .TAPS(4'b1100), .LOCK_CNT(4), .ERR_LIMIT(3)) dut (
        .Clk(Clk), .Rst(rst), .In(din), .In_Valid(valid),
        .Locked(locked), .Err(err), .Err_Count(err_count)
    );

    lfsr_seq_checker #(.W(4), .TAPS(4'b1100), .LOCK_CNT(4), .ERR_LIMIT(255)) dut_sat (
        .Clk(Clk), .Rst(s_rst), .In(s_din), .In_Valid(s_valid),
        .Locked(s_locked), .Err(s_err), .Err_Count(s_count)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [3:0]  din;
        logic        e_lock;
        logic        e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    // Reference LFSR step written arithmetically: shift left, append parity of tapped bits.
    function automatic logic [3:0] ref_next(input logic [3:0] x);
        int fb;
        fb = $countones(x & 4'b1100) % 2;
        return 4'((int'(x) * 2 + fb) % 16);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [3:0] d,
                       input logic l, input logic e, input logic [15:0] c);
        vec_t t;
        t.rst = r; t.vld = v; t.din = d; t.e_lock = l; t.e_err = e; t.e_cnt = c;
        tbl.push_back(t);
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] d);
        @(negedge Clk);
        rst = r; valid = v; din = d;
        @(posedge Clk);
        #1;
    endtask

    task automatic s_step(input logic r, input logic v, input logic [3:0] d);
        @(negedge Clk);
        s_rst = r; s_valid = v; s_din = d;
        @(posedge Clk);
        #1;
    endtask

    // Behavioural model: mode 0 = waiting for seed, 1 = hunting, 2 = locked.
    int         m_mode, m_good, m_bad, m_total;
    logic [3:0] m_pred;
    logic       m_locked, m_err;

    task automatic model(input logic r, input logic v, input logic [3:0] d);
        logic ok;
        m_err = 1'b0;
        if (!r) begin
            m_mode = 0; m_good = 0; m_bad = 0; m_total = 0;
            m_pred = 4'h0; m_locked = 1'b0;
        end else if (v) begin
            if (m_mode == 2) begin
                ok     = (d == m_pred);
                m_pred = ref_next(m_pred);
                if (ok) m_bad = 0;
                else begin
                    m_err   = 1'b1;
                    m_total = (m_total < 65535) ? m_total + 1 : 65535;
                    m_bad++;
                    if (m_bad == ELIM) begin
                        m_mode = 0; m_locked = 1'b0; m_bad = 0;
                    end
                end
            end else if (m_mode == 1 && d == m_pred) begin
                m_pred = ref_next(d);
                m_good++;
                if (m_good == LCNT) begin
                    m_mode = 2; m_locked = 1'b1; m_bad = 0;
                end
            end else if (d != 4'h0) begin
                m_mode = 1; m_pred = ref_next(d); m_good = 0;
            end else begin
                m_mode = 0;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] vals [5];
        logic [3:0] tv;
        logic       r, v;
        logic [3:0] d;
        int         rate, mism, run;

        rst = 1'b0; valid = 1'b0; din = 4'h0;
        s_rst = 1'b0; s_valid = 1'b0; s_din = 4'h0;

        // Lock acquisition, single corruption, loss of lock, relock, invalid-cycle hold.
        add(0, 0, 4'h0, 0, 0, 0);
        add(1, 1, 4'h1, 0, 0, 0);
        add(1, 1, 4'h2, 0, 0, 0);
        add(1, 1, 4'h4, 0, 0, 0);
        add(1, 1, 4'h9, 0, 0, 0);
        add(1, 1, 4'h3, 1, 0, 0);
        add(1, 1, 4'h0, 1, 1, 1);
        add(1, 1, 4'hD, 1, 0, 1);
        add(1, 1, 4'hA, 1, 0, 1);
        add(1, 1, 4'hF, 1, 1, 2);
        add(1, 1, 4'hF, 1, 1, 3);
        add(1, 1, 4'hF, 0, 1, 4);
        add(1, 1, 4'hF, 0, 0, 4);
        add(1, 1, 4'hE, 0, 0, 4);
        add(1, 1, 4'hC, 0, 0, 4);
        add(1, 1, 4'h8, 0, 0, 4);
        add(1, 1, 4'h1, 1, 0, 4);
        add(1, 0, 4'h5, 1, 0, 4);
        add(1, 1, 4'h2, 1, 0, 4);
        add(1, 1, 4'h0, 1, 1, 5);
        add(1, 0, 4'h0, 1, 0, 5);
        add(1, 1, 4'h9, 1, 0, 5);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].din);
            check($sformatf("vec%0d locked", i), 32'(locked), 32'(tbl[i].e_lock));
            check($sformatf("vec%0d err", i), 32'(err), 32'(tbl[i].e_err));
            check($sformatf("vec%0d err_count", i), 32'(err_count), 32'(tbl[i].e_cnt));
        end

        // Zero input held after reset must never seed or flag.
        step(0, 0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 4'h0);
            check("zero_idle", {30'b0, locked, err}, 32'h0);
        end

        // Correct stream with invalid gaps carrying garbage.
        vals[0] = 4'h1; vals[1] = 4'h2; vals[2] = 4'h4; vals[3] = 4'h9; vals[4] = 4'h3;
        for (int k = 0; k < 5; k++) begin
            step(1, 1, vals[k]);
            check($sformatf("gap_lock%0d", k), 32'(locked), 32'(k == 4));
            if (k < 4) begin
                step(1, 0, 4'h7);
                check($sformatf("gap_hold%0d", k), 32'(locked), 32'h0);
            end
        end
        step(1, 0, 4'h0);
        check("gap_invalid_locked", {15'b0, locked, err, err_count}, {15'b0, 2'b10, 16'h0});

        // Build Err_Count=2 while staying locked.
        step(1, 1, 4'h0);
        check("pre_rst_err1", {15'b0, locked, err, err_count}, {15'b0, 2'b11, 16'h1});
        step(1, 1, 4'hD);
        step(1, 1, 4'h0);
        step(1, 1, 4'h5);
        check("pre_rst_state", {15'b0, locked, err, err_count}, {15'b0, 2'b10, 16'h2});

        // Reset pulse between edges is ignored.
        @(negedge Clk);
        rst = 1'b0; valid = 1'b1; din = 4'hF;
        #2;
        rst = 1'b1; valid = 1'b0;
        @(posedge Clk);
        #1;
        check("rst_glitch", {15'b0, locked, err, err_count}, {15'b0, 2'b10, 16'h2});

        // Reset at an edge with a mismatching sample clears everything.
        step(0, 1, 4'hF);
        check("rst_sync", {15'b0, locked, err, err_count}, 32'h0);
        step(1, 1, 4'h0);
        check("rst_then_zero", {15'b0, locked, err, err_count}, 32'h0);

        // Randomized stream against the model.
        step(0, 0, 4'h0);
        model(0, 0, 4'h0);
        tv = 4'($urandom_range(1, 15));
        for (int i = 0; i < 3000; i++) begin
            rate = ((i / 500) % 2 == 1) ? 50 : 10;
            r = ($urandom_range(0, 299) != 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) tv = 4'($urandom_range(1, 15));
            d = ($urandom_range(0, 99) < rate) ? 4'($urandom) : tv;
            if (v) tv = ref_next(tv);
            step(r, v, d);
            model(r, v, d);
            check($sformatf("rand%0d", i), {14'b0, locked, err, err_count},
                  {14'b0, m_locked, m_err, 16'(m_total)});
        end

        // Saturation: runs of 254 mismatches separated by one good sample keep lock.
        s_step(0, 0, 4'h0);
        tv = 4'h1;
        for (int k = 0; k < 5; k++) begin
            s_step(1, 1, tv);
            tv = ref_next(tv);
        end
        check("sat_locked", 32'(s_locked), 32'h1);
        mism = 0;
        while (mism < 65537) begin
            run = (65537 - mism < 254) ? 65537 - mism : 254;
            for (int j = 0; j < run; j++) begin
                s_step(1, 1, ~tv);
                tv = ref_next(tv);
                mism++;
                if (mism == 65534) check("sat_fffe", 32'(s_count), 32'hFFFE);
                if (mism == 65535) check("sat_ffff", 32'(s_count), 32'hFFFF);
                if (mism == 65537) check("sat_hold", {15'b0, s_locked, s_err, s_count},
                                         {15'b0, 2'b11, 16'hFFFF});
            end
            s_step(1, 1, tv);
            tv = ref_next(tv);
        end
        check("sat_final", {15'b0, s_locked, s_err, s_count}, {15'b0, 2'b10, 16'hFFFF});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Downstream consumer of four_bit_LFSR.
- Samples the LFSR output stream and self-synchronises a local predictor to it using the same polynomial.
- Declares lock after a run of correct predictions, then flags and counts every mismatched sample.
- Used as the on-chip pass/fail monitor for the LFSR pattern path.

Parameters:
- W, 4, data width (matches LFSR Out width); legal W >= 3.
- TAPS, 4'b1100, feedback mask: fb = XOR-reduce(Cur & TAPS); next(Cur) = {Cur[W-2:0], fb}.
- LOCK_CNT, 4, consecutive correct predictions after seeding needed to declare lock; legal 1..255.
- ERR_LIMIT, 3, consecutive mismatches while locked that force loss of lock; legal 1..255.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  reset; synchronous, active-low (0 = reset, sampled on rising Clk).
- In  input  W  sample from upstream LFSR (connects to Out).
- In_Valid  input  1  In is a valid sample this cycle.
- Locked  output  1  registered; 1 while in LOCKED state.
- Err  output  1  registered; single-cycle pulse per mismatched sample while locked.
- Err_Count  output  16  registered; saturating total mismatch count.

Behaviour:
- Reset (Rst==0 at a rising edge): state=SEED, Locked=0, Err=0, Err_Count=0, Pred=0, match and error-run counters=0. Reset applies even mid-lock. Err_Count is cleared only by reset.
- All decisions use samples with In_Valid==1. With In_Valid==0 all state holds and Err=0 on the next cycle.
- Default Err each valid cycle is 0 unless set below.
- SEED state:
  - Valid In!=0: Pred<=next(In), MatchCnt<=0, go to HUNT.
  - Valid In==0 (LFSR lock-up value): stay in SEED.
- HUNT state (no Err, no Err_Count change):
  - In==Pred: Pred<=next(In), MatchCnt++. When MatchCnt reaches LOCK_CNT, go to LOCKED, Locked<=1, ErrRun<=0, in the same edge.
  - In!=Pred and In!=0: reseed from In; Pred<=next(In), MatchCnt<=0, stay in HUNT.
  - In!=Pred and In==0: go to SEED.
- LOCKED state (flywheel):
  - On every valid sample, Pred<=next(Pred). Pred is never reloaded from In, so one corrupt sample does not desynchronise the checker.
  - Match: ErrRun<=0.
  - Mismatch: Err<=1 for one cycle. Err_Count<=Err_Count+1, saturating at 16'hFFFF. ErrRun++.
  - When ErrRun reaches ERR_LIMIT: go to SEED and set Locked<=0 at that edge. The Err pulse for that sample is still issued.
- Latency: Err and Locked change one cycle after the sampling edge, i.e. visible immediately after the rising edge that captures In.
- Back-to-back valid samples are supported every cycle.

Test Plan:
- Lock acquisition (W=4, TAPS=1100, LOCK_CNT=4): after reset, drive a continuous valid stream 0001,0010,0100,1001,0011,0110,1101,... -> Locked rises after the edge sampling 0011 (5th sample). Err stays 0 and Err_Count=0.
- Single corruption while locked: replace 0110 with 0000, then continue 1101,1010 -> Err pulses exactly one cycle, Err_Count=1, Locked stays 1, and the following samples produce no Err.
- Loss of lock (ERR_LIMIT=3): while locked, replace three consecutive expected values with 1111 -> three Err pulses, Err_Count +3, Locked falls after the third. A subsequent clean stream relocks after 5 valid samples.
- Zero/idle input: hold In=0000 with In_Valid=1 for 20 cycles after reset -> stays in SEED, Locked=0, Err never asserts. Then a correct stream with In_Valid toggling 1/0 -> locks after 5 valid samples, with state held on invalid cycles.
- Synchronous reset mid-operation: while locked with Err_Count=2, drive Rst=0 for one edge -> at that edge Locked=0, Err=0, Err_Count=0. Rst going low between edges has no effect until the next rising edge.
- Saturation: force 65537 mismatches while locked (ERR_LIMIT=255, corrupt every 2nd sample) -> Err_Count holds at 16'hFFFF with no wrap to 0.
